// File: rtl/store_queue.sv
// Store queue: formats byte/half/word stores into lane-aligned word writes and
// buffers them in a first-word fall-through FIFO in front of data memory.
module store_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [ADDR_W-1:0]        req_addr_i,
   input  logic [31:0]              req_data_i,
   input  logic [1:0]               req_sel_i,
   output logic                     mem_valid_o,
   input  logic                     mem_ready_i,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic [31:0]              mem_wdata_o,
   output logic [3:0]               mem_wstrb_o,
   output logic                     misalign_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [PW-1:0] ONE_PTR  = PW'(1);

   // SB any offset, SH halfword aligned, SW word aligned, sel 11 never.
   function automatic logic f_legal(input logic [1:0] sel, input logic [1:0] off);
      case (sel)
         2'b00:   f_legal = 1'b1;
         2'b01:   f_legal = ~off[0];
         2'b10:   f_legal = (off == 2'b00);
         default: f_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] f_wdata(input logic [1:0] sel, input logic [31:0] data);
      case (sel)
         2'b00:   f_wdata = {4{data[7:0]}};
         2'b01:   f_wdata = {2{data[15:0]}};
         default: f_wdata = data;
      endcase
   endfunction

   function automatic logic [3:0] f_wstrb(input logic [1:0] sel, input logic [1:0] off);
      case (sel)
         2'b00:   f_wstrb = 4'b0001 << off;
         2'b01:   f_wstrb = 4'b0011 << off;
         default: f_wstrb = 4'b1111;
      endcase
   endfunction

   logic [ADDR_W-1:0] r_addr_q [DEPTH];
   logic [31:0]       r_data_q [DEPTH];
   logic [3:0]        r_strb_q [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic              r_misalign;

   logic              w_legal;
   logic              w_fire;
   logic              w_push;
   logic              w_pop;
   logic [CW-1:0]     w_count_nxt;

   // Handshake decode; a full queue stays closed even if the head retires now.
   always_comb begin
      req_ready_o = (r_count < FULL_CNT);
      mem_valid_o = (r_count != {CW{1'b0}});
      w_legal     = f_legal(req_sel_i, req_addr_i[1:0]);
      w_fire      = req_valid_i && req_ready_o;
      w_push      = w_fire && w_legal;
      w_pop       = mem_valid_o && mem_ready_i;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + ONE_CNT;
         2'b01:   w_count_nxt = r_count - ONE_CNT;
         default: w_count_nxt = r_count;
      endcase
   end

   // Head entry is shown straight from storage, forced to zero when empty.
   always_comb begin
      if (mem_valid_o) begin
         mem_addr_o  = r_addr_q[r_rptr];
         mem_wdata_o = r_data_q[r_rptr];
         mem_wstrb_o = r_strb_q[r_rptr];
      end else begin
         mem_addr_o  = {ADDR_W{1'b0}};
         mem_wdata_o = 32'h0000_0000;
         mem_wstrb_o = 4'b0000;
      end
      count_o    = r_count;
      misalign_o = r_misalign;
   end

   // Pointer, occupancy and misalign-pulse state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= {PW{1'b0}};
         r_rptr     <= {PW{1'b0}};
         r_count    <= {CW{1'b0}};
         r_misalign <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + ONE_PTR;
         end else begin
            r_wptr <= r_wptr;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + ONE_PTR;
         end else begin
            r_rptr <= r_rptr;
         end
         r_count    <= w_count_nxt;
         r_misalign <= w_fire && !w_legal;
      end
   end

   // Entry storage; contents are don't-care until their slot is counted.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_addr_q[r_wptr] <= {req_addr_i[ADDR_W-1:2], 2'b00};
         r_data_q[r_wptr] <= f_wdata(req_sel_i, req_data_i);
         r_strb_q[r_wptr] <= f_wstrb(req_sel_i, req_addr_i[1:0]);
      end
   end

endmodule

// File: tb/tb_store_queue.sv
// Scoreboard bench for store_queue: accepted stores are modelled at the
// request side and compared against the mem port as the head is presented.
module tb_store_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic [31:0] req_data_i;
   logic [1:0]  req_sel_i;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        misalign_o;
   logic [2:0]  count_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ent_t;

   ent_t sb[$];
   ent_t e_new;
   bit   exp_mis = 1'b0;

   store_queue #(.DEPTH(4), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_data_i  (req_data_i),
      .req_sel_i   (req_sel_i),
      .mem_valid_o (mem_valid_o),
      .mem_ready_i (mem_ready_i),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_wstrb_o (mem_wstrb_o),
      .misalign_o  (misalign_o),
      .count_o     (count_o)
   );

   always #5 clk = ~clk;

   function automatic bit tb_legal(input logic [1:0] sel, input logic [31:0] addr);
      if (sel == 2'b00) return 1'b1;
      if (sel == 2'b01) return addr[0] == 1'b0;
      if (sel == 2'b10) return addr[1:0] == 2'b00;
      return 1'b0;
   endfunction

   function automatic ent_t tb_fmt(input logic [1:0] sel, input logic [31:0] addr,
                                   input logic [31:0] data);
      ent_t e;
      e.a = addr & 32'hFFFF_FFFC;
      if (sel == 2'b00) begin
         e.d = {data[7:0], data[7:0], data[7:0], data[7:0]};
         e.s = 4'b0001 << addr[1:0];
      end else if (sel == 2'b01) begin
         e.d = {data[15:0], data[15:0]};
         e.s = 4'b0011 << addr[1:0];
      end else begin
         e.d = data;
         e.s = 4'b1111;
      end
      return e;
   endfunction

   // Scoreboard: compare state mid-cycle, then apply the upcoming edge's push/pop.
   always @(negedge clk) begin
      n_tests++;
      if (count_o !== 3'(sb.size())) begin
         n_fail++;
         $display("FAIL sb_count: got %0d want %0d @%0t", count_o, sb.size(), $time);
      end
      n_tests++;
      if (misalign_o !== exp_mis) begin
         n_fail++;
         $display("FAIL sb_misalign: got %b want %b @%0t", misalign_o, exp_mis, $time);
      end
      n_tests++;
      if (sb.size() == 0) begin
         if ({mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== 69'd0) begin
            n_fail++;
            $display("FAIL sb_empty_port: got v=%b a=%h d=%h s=%b want all zero @%0t",
                     mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, $time);
         end
      end else begin
         if (mem_valid_o !== 1'b1 || {mem_addr_o, mem_wdata_o, mem_wstrb_o} !== sb[0]) begin
            n_fail++;
            $display("FAIL sb_head: got v=%b a=%h d=%h s=%b want v=1 a=%h d=%h s=%b @%0t",
                     mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
                     sb[0].a, sb[0].d, sb[0].s, $time);
         end
      end
      if (rst) begin
         sb.delete();
         exp_mis = 1'b0;
      end else begin
         if (mem_ready_i && sb.size() != 0) void'(sb.pop_front());
         if (req_valid_i && req_ready_o) begin
            if (tb_legal(req_sel_i, req_addr_i)) begin
               e_new = tb_fmt(req_sel_i, req_addr_i, req_data_i);
               sb.push_back(e_new);
               exp_mis = 1'b0;
            end else begin
               exp_mis = 1'b1;
            end
         end else begin
            exp_mis = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      req_valid_i = 1'b1;
      req_addr_i  = a;
      req_data_i  = d;
      req_sel_i   = s;
   endtask

   task automatic drain();
      bit done = 1'b0;
      req_valid_i = 1'b0;
      mem_ready_i = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         if (count_o == 3'd0) done = 1'b1;
         else step();
      end
      n_tests++;
      if (count_o !== 3'd0) begin
         n_fail++;
         $display("FAIL drain_timeout: got count %0d want 0", count_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid_i = 1'b1; mem_ready_i = 1'b1;
      put(32'h0000_0010, 32'h1111_2222, 2'b10);
      step(); step();
      rst = 1'b0; req_valid_i = 1'b0;
      n_tests++;
      if ({count_o, mem_valid_o, misalign_o, req_ready_o} !== 6'b000_0_0_1) begin
         n_fail++;
         $display("FAIL reset_ctrl: got cnt=%0d v=%b mis=%b rdy=%b want 0 0 0 1",
                  count_o, mem_valid_o, misalign_o, req_ready_o);
      end
      n_tests++;
      if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset_fields: got a=%h d=%h s=%b want 0", mem_addr_o, mem_wdata_o, mem_wstrb_o);
      end
   endtask

   task automatic test_sb();
      mem_ready_i = 1'b1;
      put(32'h0000_1003, 32'hAABB_CCDD, 2'b00);
      step();
      req_valid_i = 1'b0;
      n_tests++;
      if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h0000_1000 ||
          mem_wdata_o !== 32'hDDDD_DDDD || mem_wstrb_o !== 4'b1000) begin
         n_fail++;
         $display("FAIL sb_format: got v=%b a=%h d=%h s=%b want 1 00001000 dddddddd 1000",
                  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
      end
      drain();
   endtask

   task automatic test_sh();
      mem_ready_i = 1'b0;
      put(32'h0000_2002, 32'h1234_5678, 2'b01);
      step();
      req_valid_i = 1'b0;
      n_tests++;
      if (mem_wdata_o !== 32'h5678_5678 || mem_wstrb_o !== 4'b1100 || count_o !== 3'd1) begin
         n_fail++;
         $display("FAIL sh_format: got d=%h s=%b cnt=%0d want 56785678 1100 1",
                  mem_wdata_o, mem_wstrb_o, count_o);
      end
      put(32'h0000_2001, 32'h1234_5678, 2'b01);
      step();
      req_valid_i = 1'b0;
      n_tests++;
      if (misalign_o !== 1'b1 || count_o !== 3'd1) begin
         n_fail++;
         $display("FAIL sh_misalign: got mis=%b cnt=%0d want 1 1", misalign_o, count_o);
      end
      step();
      n_tests++;
      if (misalign_o !== 1'b0) begin
         n_fail++;
         $display("FAIL sh_pulse_width: got mis=%b want 0", misalign_o);
      end
      drain();
   endtask

   task automatic test_full();
      mem_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         put(32'h0000_0100 * i, 32'(i), 2'b10);
         step();
      end
      n_tests++;
      if (count_o !== 3'd4 || req_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_state: got cnt=%0d rdy=%b want 4 0", count_o, req_ready_o);
      end
      put(32'h0000_0500, 32'd5, 2'b10);
      step();
      n_tests++;
      if (count_o !== 3'd4) begin
         n_fail++;
         $display("FAIL full_reject: got cnt=%0d want 4", count_o);
      end
      mem_ready_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      n_tests++;
      if (count_o !== 3'd3 || req_ready_o !== 1'b1 || mem_wdata_o !== 32'd2) begin
         n_fail++;
         $display("FAIL full_pop_no_bypass: got cnt=%0d rdy=%b head=%h want 3 1 2",
                  count_o, req_ready_o, mem_wdata_o);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      mem_ready_i = 1'b1;
      put(32'h0000_4000, 32'h0000_0100, 2'b10);
      step();
      for (int i = 1; i <= 10; i++) begin
         put(32'h0000_4000 + 32'(4 * i), 32'h0000_0100 + 32'(i), 2'b10);
         step();
         n_tests++;
         if (count_o !== 3'd1 || mem_wdata_o !== 32'h0000_0100 + 32'(i)) begin
            n_fail++;
            $display("FAIL wrap_pair%0d: got cnt=%0d d=%h want 1 %h",
                     i, count_o, mem_wdata_o, 32'h0000_0100 + 32'(i));
         end
      end
      drain();
   endtask

   task automatic test_illegal_pop();
      mem_ready_i = 1'b0;
      put(32'h0000_5000, 32'hCAFE_0001, 2'b10); step();
      put(32'h0000_5004, 32'hCAFE_0002, 2'b10); step();
      put(32'h0000_5008, 32'hCAFE_0003, 2'b11);
      mem_ready_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      n_tests++;
      if (count_o !== 3'd1 || misalign_o !== 1'b1 || mem_wdata_o !== 32'hCAFE_0002) begin
         n_fail++;
         $display("FAIL illegal_pop: got cnt=%0d mis=%b d=%h want 1 1 cafe0002",
                  count_o, misalign_o, mem_wdata_o);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      mem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         put(32'h0000_6000 + 32'(i), 32'h0000_00A0 + 32'(i), 2'b00);
         step();
      end
      put(32'h0000_6002, 32'h0000_00FF, 2'b10);
      step();
      n_tests++;
      if (misalign_o !== 1'b1 || count_o !== 3'd3) begin
         n_fail++;
         $display("FAIL midrst_pre: got mis=%b cnt=%0d want 1 3", misalign_o, count_o);
      end
      rst = 1'b1;
      put(32'h0000_6001, 32'h0000_00EE, 2'b10);
      mem_ready_i = 1'b1;
      step();
      rst = 1'b0;
      req_valid_i = 1'b0;
      n_tests++;
      if ({count_o, mem_valid_o, misalign_o, req_ready_o} !== 6'b000_0_0_1 ||
          {mem_addr_o, mem_wdata_o, mem_wstrb_o} !== 68'd0) begin
         n_fail++;
         $display("FAIL midrst_post: got cnt=%0d v=%b mis=%b rdy=%b a=%h d=%h s=%b want 0 0 0 1 zeros",
                  count_o, mem_valid_o, misalign_o, req_ready_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         req_valid_i = 1'($urandom_range(0, 1));
         req_addr_i  = $urandom;
         req_data_i  = $urandom;
         req_sel_i   = 2'($urandom_range(0, 3));
         mem_ready_i = ($urandom_range(0, 2) != 0);
         step();
      end
      drain();
   endtask

   initial begin
      rst = 1'b1; req_valid_i = 1'b0; mem_ready_i = 1'b0;
      req_addr_i = 32'd0; req_data_i = 32'd0; req_sel_i = 2'b00;
      test_reset();
      test_sb();
      test_sh();
      test_full();
      test_back_to_back();
      test_illegal_pop();
      test_reset_mid();
      test_random();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
